// File: rtl/fir_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_scheduler
// Purpose  : Sequences one shared MAC over all FIR taps using a circular delay
//            line. Optional macro FIR_SCHED_OVERRUN_CNT_EN adds overrunCount.
// Revision : 1.0  initial release
// ============================================================================
module fir_tap_scheduler #(
    parameter int NTaps      = 8,
    parameter int AddrWidth  = $clog2(NTaps),
    parameter int MacLatency = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 lock,
    output logic                 busy,
    output logic                 sampleWe,
    output logic [AddrWidth-1:0] sampleAddr,
    output logic [AddrWidth-1:0] coeffAddr,
    output logic                 macEn,
    output logic                 macClear,
    output logic                 done,
    output logic                 overrun
`ifdef FIR_SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrunCount
`endif
);

    localparam int CNT_MAX   = (NTaps > MacLatency) ? NTaps : MacLatency;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0] LAST_TAP   = CNT_WIDTH'(NTaps - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_DRAIN = CNT_WIDTH'((MacLatency > 0) ? MacLatency - 1 : 0);
    localparam logic [AddrWidth-1:0] LAST_ADDR  = AddrWidth'(NTaps - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]           state;
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 pending;
    logic                 accept;
    logic                 drop;

    // A start is only taken when idle with nothing queued; anything else is lost.
    assign accept = start && (state == ST_IDLE) && !pending;
    assign drop   = start && !accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!lock && (pending || accept)) begin
                        pending <= 1'b0;
                        state   <= ST_WRITE;
                    end else if (accept) begin
                        pending <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    cnt    <= '0;
                    rd_ptr <= wr_ptr;
                    state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt == LAST_TAP) begin
                        cnt   <= '0;
                        state <= (MacLatency == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        // Explicit wrap so non-power-of-two tap counts stay in range.
                        rd_ptr <= (rd_ptr == '0) ? LAST_ADDR : rd_ptr - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == LAST_DRAIN) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIR_SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrunCount <= '0;
        end else if (drop && (overrunCount != 8'hFF)) begin
            overrunCount <= overrunCount + 8'd1;
        end
    end
`endif

    always_comb begin
        busy       = (state != ST_IDLE) || pending;
        sampleWe   = (state == ST_WRITE);
        macEn      = (state == ST_RUN);
        macClear   = (state == ST_RUN) && (cnt == '0);
        done       = (state == ST_DONE);
        sampleAddr = '0;
        coeffAddr  = '0;
        if (state == ST_WRITE) begin
            sampleAddr = wr_ptr;
        end else if (state == ST_RUN) begin
            sampleAddr = rd_ptr;
            coeffAddr  = cnt[AddrWidth-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_tap_scheduler
// Purpose  : Directed self-checking bench for fir_tap_scheduler (8/2 and 5/0).
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_tap_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       lock = 1'b0;
    logic       busy, sampleWe, macEn, macClear, done, overrun;
    logic [2:0] sampleAddr, coeffAddr;

    logic       start5 = 1'b0;
    logic       lock5 = 1'b0;
    logic       busy5, sampleWe5, macEn5, macClear5, done5, overrun5;
    logic [2:0] sampleAddr5, coeffAddr5;
`ifdef FIR_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrunCount, overrunCount5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_tap_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .lock(lock), .busy(busy),
        .sampleWe(sampleWe), .sampleAddr(sampleAddr), .coeffAddr(coeffAddr),
        .macEn(macEn), .macClear(macClear), .done(done), .overrun(overrun)
`ifdef FIR_SCHED_OVERRUN_CNT_EN
        , .overrunCount(overrunCount)
`endif
    );

    fir_tap_scheduler #(.NTaps(5), .MacLatency(0)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .lock(lock5), .busy(busy5),
        .sampleWe(sampleWe5), .sampleAddr(sampleAddr5), .coeffAddr(coeffAddr5),
        .macEn(macEn5), .macClear(macClear5), .done(done5), .overrun(overrun5)
`ifdef FIR_SCHED_OVERRUN_CNT_EN
        , .overrunCount(overrunCount5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the WRITE cycle of the 8-tap instance; ends one cycle after DONE.
    task automatic body8(input int wp);
        chk("w_we", sampleWe, 1);
        chk("w_addr", sampleAddr, wp);
        chk("w_busy", busy, 1);
        chk("w_mac", macEn, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("r_mac", macEn, 1);
            chk("r_clr", macClear, (k == 0) ? 1 : 0);
            chk("r_coef", coeffAddr, k);
            chk("r_saddr", sampleAddr, (wp - k + 8) % 8);
            chk("r_we", sampleWe, 0);
            chk("r_done", done, 0);
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            chk("d_mac", macEn, 0);
            chk("d_done", done, 0);
            chk("d_saddr", sampleAddr, 0);
        end
        tick();
        chk("done", done, 1);
        chk("done_mac", macEn, 0);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic run8(input int wp);
        start = 1'b1;
        tick();
        start = 1'b0;
        body8(wp);
    endtask

    task automatic run5(input int wp);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk("n5_we", sampleWe5, 1);
        chk("n5_waddr", sampleAddr5, wp);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("n5_mac", macEn5, 1);
            chk("n5_clr", macClear5, (k == 0) ? 1 : 0);
            chk("n5_coef", coeffAddr5, k);
            chk("n5_saddr", sampleAddr5, (wp - k + 5) % 5);
            chk("n5_lt5", (sampleAddr5 < 3'd5) ? 1 : 0, 1);
            chk("n5_done", done5, 0);
        end
        tick();
        chk("n5_doneT7", done5, 1);
        chk("n5_dmac", macEn5, 0);
        tick();
        chk("n5_idle", busy5, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_we", sampleWe, 0);
        chk("rst_saddr", sampleAddr, 0);
        chk("rst_coef", coeffAddr, 0);
        chk("rst_mac", macEn, 0);
        chk("rst_clr", macClear, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun, 0);

        // Single sample, then eight more back-to-back: write pointer 0..7,0
        run8(0);
        for (int s = 1; s < 9; s++) begin
            run8(s % 8);
        end

        // Launch held off by lock for 20 cycles
        lock = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            chk("lk_busy", busy, 1);
            chk("lk_we", sampleWe, 0);
            tick();
        end
        lock = 1'b0;
        chk("lk_busy_last", busy, 1);
        chk("lk_we_last", sampleWe, 0);
        tick();
        body8(1);
        chk("lk_ovr", overrun, 0);

        // Second start during RUN is dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ov_we", sampleWe, 1);
        chk("ov_addr", sampleAddr, 2);
        repeat (4) tick();
        start = 1'b1;
        chk("ov_pre", overrun, 0);
        tick();
        start = 1'b0;
        for (int c = 6; c < 12; c++) begin
            chk("ov_sticky", overrun, 1);
            chk("ov_nodone", done, 0);
            tick();
        end
        chk("ov_doneT12", done, 1);
        tick();
        chk("ov_single_done", done, 0);
        chk("ov_busy", busy, 0);
        chk("ov_hold", overrun, 1);
        repeat (3) tick();
        chk("ov_hold2", overrun, 1);
        chk("ov_extra_done", done, 0);
`ifdef FIR_SCHED_OVERRUN_CNT_EN
        chk("ovc_one", overrunCount, 1);
        do_reset();
        chk("ovc_rst", overrunCount, 0);
        lock = 1'b1;
        start = 1'b1;
        repeat (301) tick();
        start = 1'b0;
        chk("ovc_sat", overrunCount, 255);
        lock = 1'b0;
        repeat (15) tick();
`endif

        // Reset in the middle of a run
        do_reset();
        run8(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_we", sampleWe, 0);
        chk("mr_saddr", sampleAddr, 0);
        chk("mr_coef", coeffAddr, 0);
        chk("mr_mac", macEn, 0);
        chk("mr_clr", macClear, 0);
        chk("mr_done", done, 0);
        chk("mr_ovr", overrun, 0);
        for (int i = 0; i < 8; i++) begin
            chk("mr_nodone", done, 0);
            tick();
        end
        run8(0);

        // Non-power-of-two taps with zero MAC latency
        chk("n5_rst_busy", busy5, 0);
        for (int s = 0; s < 6; s++) begin
            run5(s % 5);
        end
        chk("n5_ovr", overrun5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
